// File: rtl/prog_mem_loader_pkg.sv
// Shared definitions for the program-memory loader.
// Holds the loader state encoding, the frame sync byte and the program
// memory geometry shared with the program memory itself.
package prog_mem_loader_pkg;

  localparam int         PM_WORD_AW    = 11;
  localparam int         PM_MEM_DEPTH  = 2048;
  localparam int         PM_DATA_WIDTH = 32;
  localparam logic [7:0] PM_MAGIC      = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } loader_state_t;

endpackage

// File: rtl/prog_mem_loader_word_packer.sv
// Packs accepted bytes into 32-bit big-endian words.
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   clear       : restart packing at byte 0 (new frame)
//   accept      : byte_in is taken this cycle
//   byte_in     : payload byte
//   word        : packed word (valid while word_valid is high)
//   word_valid  : one-cycle strobe, the cycle after the 4th byte is taken
module prog_word_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  byte_cnt;
  logic [31:0] shift_q;

  // Shifting left puts the first byte of a group in [31:24].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt   <= 2'd0;
      shift_q    <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        byte_cnt <= 2'd0;
        shift_q  <= '0;
      end else if (accept) begin
        shift_q    <= {shift_q[23:0], byte_in};
        byte_cnt   <= byte_cnt + 2'd1;
        word_valid <= (byte_cnt == 2'd3);
      end
    end
  end

  assign word = shift_q;

endmodule

// File: rtl/prog_mem_loader.sv
// Boot-time program loader: receives a framed byte stream, writes it into
// program memory word by word and releases the core only after the
// checksum matches.
// Ports:
//   clk, rst_n      : clock, async active-low reset
//   start           : pulse, arms the loader when not busy
//   in_valid/in_data/in_ready : byte stream handshake
//   mem_we/mem_addr/mem_wdata : program memory write port
//   cpu_rst_n       : core reset, low holds the core
//   busy/done/error : loader status
//   words_written   : words written in the current frame
//
// state    | meaning
// IDLE     | after reset, waiting for start
// SYNC     | discarding bytes until MAGIC
// LEN_HI   | taking word count high byte
// LEN_LO   | taking word count low byte, length check
// DATA     | taking payload, one memory write per 4 bytes
// CHECK    | taking and comparing the checksum byte
// DONE     | image good, core released
// ERROR    | oversize length or bad checksum, core held
module prog_mem_loader
  import prog_mem_loader_pkg::*;
#(
  parameter int         WORD_AW    = PM_WORD_AW,
  parameter int         MEM_DEPTH  = PM_MEM_DEPTH,
  parameter int         DATA_WIDTH = PM_DATA_WIDTH,
  parameter logic [7:0] MAGIC      = PM_MAGIC
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [WORD_AW-1:0]    mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  cpu_rst_n,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [WORD_AW:0]      words_written
);

  localparam logic [16:0] DEPTH_L = 17'(MEM_DEPTH);

  loader_state_t state_q, state_d;

  logic [15:0]      len_q;
  logic [15:0]      len_rx;
  logic [7:0]       chk_q;
  logic [1:0]       byte_cnt_q;
  logic [WORD_AW:0] ww_next;
  logic             arm;
  logic             take;

  assign arm     = start && !busy;
  assign take    = in_valid && in_ready;
  assign len_rx  = {len_q[15:8], in_data};
  assign ww_next = words_written + 1'b1;

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    busy     = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) state_d = ST_SYNC;
      end
      ST_SYNC: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid && in_data == MAGIC) state_d = ST_LEN_HI;
      end
      ST_LEN_HI: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) state_d = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) begin
          if ({1'b0, len_rx} > DEPTH_L) state_d = ST_ERROR;
          else if (len_rx == 16'd0)     state_d = ST_CHECK;
          else                          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid && byte_cnt_q == 2'd3 && 16'(ww_next) == len_q)
          state_d = ST_CHECK;
      end
      ST_CHECK: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) state_d = (in_data == chk_q) ? ST_DONE : ST_ERROR;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Status flags are registered from the next state so cpu_rst_n is a
  // clean flop output rather than a decode of the state vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      len_q         <= '0;
      chk_q         <= '0;
      byte_cnt_q    <= '0;
      words_written <= '0;
      mem_addr      <= '0;
      done          <= 1'b0;
      error         <= 1'b0;
      cpu_rst_n     <= 1'b0;
    end else begin
      state_q   <= state_d;
      done      <= (state_d == ST_DONE);
      error     <= (state_d == ST_ERROR);
      cpu_rst_n <= (state_d == ST_DONE);
      if (arm) begin
        len_q         <= '0;
        chk_q         <= '0;
        byte_cnt_q    <= '0;
        words_written <= '0;
        mem_addr      <= '0;
      end else if (take) begin
        case (state_q)
          ST_LEN_HI: begin
            len_q[15:8] <= in_data;
            chk_q       <= chk_q + in_data;
          end
          ST_LEN_LO: begin
            len_q[7:0] <= in_data;
            chk_q      <= chk_q + in_data;
          end
          ST_DATA: begin
            chk_q      <= chk_q + in_data;
            byte_cnt_q <= byte_cnt_q + 2'd1;
            // Address and count land together with the packer's strobe.
            if (byte_cnt_q == 2'd3) begin
              mem_addr      <= words_written[WORD_AW-1:0];
              words_written <= ww_next;
            end
          end
          default: ;
        endcase
      end
    end
  end

  prog_word_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (arm),
    .accept     (take && state_q == ST_DATA),
    .byte_in    (in_data),
    .word       (mem_wdata),
    .word_valid (mem_we)
  );

endmodule

// File: tb/tb_prog_mem_loader.sv
module tb_prog_mem_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [10:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_rst_n;
  logic        busy;
  logic        done;
  logic        error;
  logic [11:0] words_written;

  int n_vec  = 0;
  int n_miss = 0;

  logic [10:0] wa[$];
  logic [31:0] wd[$];
  logic [11:0] ww[$];

  always #5 clk = ~clk;

  prog_mem_loader dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .cpu_rst_n     (cpu_rst_n),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .words_written (words_written)
  );

  always @(negedge clk) begin
    if (mem_we) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_wdata);
      ww.push_back(words_written);
    end
  end

  typedef struct {
    logic [0:15][7:0] bytes;
    int               n;
    bit               gaps;
    int               start_at;
    bit               exp_done;
    bit               exp_err;
    int               exp_nw;
    logic [31:0]      w0;
    logic [31:0]      w1;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Presents one byte at a negedge once in_ready is high; it is taken on
  // the following posedge. Back-to-back calls give one byte per cycle.
  task automatic send_byte(input logic [7:0] b, input bit gap, input bit st);
    int t = 0;
    @(negedge clk);
    if (gap) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
    while (!in_ready && t < 50) begin
      in_valid = 1'b0;
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("in_ready timeout", 32'd0, 32'd1);
    in_valid = 1'b1;
    in_data  = b;
    start    = st;
  endtask

  task automatic run_vec(input int i);
    vec_t v = vecs[i];
    wa.delete(); wd.delete(); ww.delete();
    pulse_start();
    check($sformatf("v%0d busy after start", i), 32'(busy), 32'd1);
    check($sformatf("v%0d cpu_rst_n after start", i), 32'(cpu_rst_n), 32'd0);
    check($sformatf("v%0d done cleared", i), 32'(done), 32'd0);
    for (int j = 0; j < v.n; j++)
      send_byte(v.bytes[j], v.gaps && (j % 2 == 1), j == v.start_at);
    @(negedge clk);
    in_valid = 1'b0;
    start    = 1'b0;
    repeat (2) @(negedge clk);
    check($sformatf("v%0d done", i), 32'(done), 32'(v.exp_done));
    check($sformatf("v%0d error", i), 32'(error), 32'(v.exp_err));
    check($sformatf("v%0d cpu_rst_n", i), 32'(cpu_rst_n), 32'(v.exp_done));
    check($sformatf("v%0d busy", i), 32'(busy), 32'd0);
    check($sformatf("v%0d in_ready", i), 32'(in_ready), 32'd0);
    check($sformatf("v%0d words_written", i), 32'(words_written), 32'(v.exp_nw));
    check($sformatf("v%0d write count", i), 32'(wd.size()), 32'(v.exp_nw));
    for (int k = 0; k < v.exp_nw && k < wd.size(); k++) begin
      check($sformatf("v%0d addr%0d", i, k), 32'(wa[k]), 32'(k));
      check($sformatf("v%0d wdata%0d", i, k), wd[k], (k == 0) ? v.w0 : v.w1);
      check($sformatf("v%0d ww at write%0d", i, k), 32'(ww[k]), 32'(k + 1));
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " in_ready"}, 32'(in_ready), 32'd0);
    check({tag, " mem_we"}, 32'(mem_we), 32'd0);
    check({tag, " mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, " mem_wdata"}, mem_wdata, 32'd0);
    check({tag, " cpu_rst_n"}, 32'(cpu_rst_n), 32'd0);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " done"}, 32'(done), 32'd0);
    check({tag, " error"}, 32'(error), 32'd0);
    check({tag, " words_written"}, 32'(words_written), 32'd0);
  endtask

  initial begin
    //                 bytes (left aligned)                                         n  gaps st   done err nw  w0            w1
    vecs[0] = '{{96'hA5_00_02_DE_AD_BE_EF_01_02_03_04_44, 32'h0}, 12, 1'b0, -1, 1'b1, 1'b0, 2, 32'hDEADBEEF, 32'h01020304};
    vecs[1] = '{{96'hA5_00_02_DE_AD_BE_EF_01_02_03_04_45, 32'h0}, 12, 1'b0, -1, 1'b0, 1'b1, 2, 32'hDEADBEEF, 32'h01020304};
    vecs[2] = '{{48'h00_FF_A5_00_00_00, 80'h0},                    6, 1'b0, -1, 1'b1, 1'b0, 0, 32'h0,        32'h0};
    vecs[3] = '{{64'hA5_00_01_12_34_56_78_15, 64'h0},              8, 1'b0, -1, 1'b1, 1'b0, 1, 32'h12345678, 32'h0};
    vecs[4] = '{{96'hA5_00_02_DE_AD_BE_EF_01_02_03_04_44, 32'h0}, 12, 1'b1,  5, 1'b1, 1'b0, 2, 32'hDEADBEEF, 32'h01020304};
    vecs[5] = '{{24'hA5_08_01, 104'h0},                            3, 1'b0, -1, 1'b0, 1'b1, 0, 32'h0,        32'h0};
    vecs[6] = '{{32'hA5_00_00_01, 96'h0},                          4, 1'b0, -1, 1'b0, 1'b1, 0, 32'h0,        32'h0};

    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_vals("idle");

    for (int i = 0; i < 7; i++) run_vec(i);

    // Oversize: error the cycle after LEN_LO is taken.
    wa.delete(); wd.delete(); ww.delete();
    pulse_start();
    send_byte(8'hA5, 1'b0, 1'b0);
    send_byte(8'h08, 1'b0, 1'b0);
    send_byte(8'h01, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    check("oversize error timing", 32'(error), 32'd1);
    check("oversize in_ready", 32'(in_ready), 32'd0);
    check("oversize no write", 32'(wd.size()), 32'd0);

    // Exactly MEM_DEPTH words is accepted.
    pulse_start();
    send_byte(8'hA5, 1'b0, 1'b0);
    send_byte(8'h08, 1'b0, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    check("depth len error", 32'(error), 32'd0);
    check("depth len in DATA", 32'(in_ready), 32'd1);

    // Reset mid-load after the 6th byte.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wa.delete(); wd.delete(); ww.delete();
    pulse_start();
    for (int j = 0; j < 6; j++) send_byte(vecs[0].bytes[j], 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    check_reset_vals("mid reset");
    in_valid = 1'b1;
    in_data  = 8'hEF;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    in_valid = 1'b0;
    check("mid reset no write", 32'(wd.size()), 32'd0);
    check("mid reset stays idle", 32'(in_ready), 32'd0);
    run_vec(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/prog_mem_loader.md
Name: prog_mem_loader

Overview:
Write-side counterpart of the instruction/program memory. It accepts a framed byte stream from a host link (UART receiver or debug bridge) over a valid/ready handshake and packs the bytes into 32-bit words. It writes those words sequentially into the program memory write port and holds the RV32i core in reset until the image is loaded and its checksum is verified. It replaces file-based preloading for on-board boot.

Parameters:
WORD_AW, 11, word-address width of the program memory write port
MEM_DEPTH, 2048, number of 32-bit words in program memory; the maximum accepted length
DATA_WIDTH, 32, memory word width; fixed at 32
MAGIC, 8'hA5, frame sync byte

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
start  in  1  single-cycle pulse; arms the loader; ignored while busy
in_valid  in  1  byte stream valid
in_data  in  8  byte stream data
in_ready  out  1  loader accepts a byte this cycle when in_valid && in_ready
mem_we  out  1  program memory write strobe, one cycle per word
mem_addr  out  WORD_AW  word index being written
mem_wdata  out  32  word being written
cpu_rst_n  out  1  core reset; low holds the core
busy  out  1  high in SYNC, LEN_HI, LEN_LO, DATA and CHECK
done  out  1  load completed with good checksum
error  out  1  load failed (oversize length or bad checksum)
words_written  out  WORD_AW+1  count of words written in the current frame

Behaviour:
- Reset: state IDLE. in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rst_n=0, busy=0, done=0, error=0, words_written=0. Reset is honoured mid-frame: the frame is abandoned and no further mem_we is issued.
- Frame format: MAGIC, LEN_HI, LEN_LO (16-bit word count N), then 4*N payload bytes, then CHK. CHK is the 8-bit sum mod 256 of LEN_HI, LEN_LO and all payload bytes.
- IDLE: in_ready=0. On start, go to SYNC; clear done, error, words_written, the checksum accumulator and the byte counter. cpu_rst_n goes 0 the cycle after start.
- SYNC: in_ready=1. An accepted byte equal to MAGIC moves to LEN_HI. Any other accepted byte is discarded.
- LEN_HI and LEN_LO: in_ready=1. Each accepted byte is latched and added to the checksum. After LEN_LO:
  - N > MEM_DEPTH: go to ERROR.
  - N == 0: go to CHECK.
  - otherwise: go to DATA.
- DATA: in_ready=1.
  - Packing order: the first byte of each group of 4 goes to bits [31:24], the last to bits [7:0]. This is the big-endian image layout the memory read path byte-swaps.
  - On acceptance of the 4th byte of word k, the next cycle carries mem_we=1, mem_addr=k, mem_wdata=the packed word, and words_written=k+1.
  - Throughput is one byte per cycle. Gaps in in_valid are allowed and the partial word is held.
  - After the 4th byte of word N-1, go to CHECK.
- CHECK: in_ready=1. On acceptance, compare the byte with the accumulator. Match goes to DONE, mismatch goes to ERROR, one cycle later.
- DONE: in_ready=0, done=1, cpu_rst_n=1, busy=0. Held until the next start.
- ERROR: in_ready=0, error=1, cpu_rst_n=0, busy=0. Held until the next start.
- Words already written before a checksum failure are not rolled back. The core simply stays in reset.
- start during busy is ignored. start in DONE or ERROR re-arms the loader: SYNC, done and error cleared, cpu_rst_n=0.
- mem_addr wraps never: N ≤ MEM_DEPTH is guaranteed by the length check.

Decomposition:
- Shared package / defines header holds:
  - the state encoding (IDLE, SYNC, LEN_HI, LEN_LO, DATA, CHECK, DONE, ERROR)
  - MAGIC
  - the memory word-address width and depth constants shared with progMem
- One sub-module, prog_word_packer:
  - Inputs: byte plus accept strobe and a clear.
  - Outputs: a 32-bit word and a one-cycle word_valid.
  - Contains a 2-bit byte counter and a shift register.
- The FSM, checksum accumulator, length check and address counter stay in prog_mem_loader.

Test Plan:
- Nominal load: start, then stream A5 00 02 DE AD BE EF 01 02 03 04 44 → writes addr0=DEADBEEF and addr1=01020304. done=1, cpu_rst_n=1, words_written=2.
- Bad checksum: same stream with final byte 45 → both writes occur, error=1, done=0, cpu_rst_n=0.
- Zero length and junk sync: stream 00 FF A5 00 00 00 → leading 00 and FF discarded, no mem_we, done=1.
- Oversize length: A5 08 01 → error=1 the cycle after LEN_LO is accepted, in_ready=0, no mem_we.
- Backpressure and gaps: nominal stream with in_valid toggled every other cycle and a start pulse mid-frame → identical writes and result; start ignored.
- Reset mid-load: assert rst_n low after the 6th byte → all outputs at reset values, no further mem_we. A fresh start plus the nominal stream then succeeds.
